chu_gpo_ext: RTL

Extended general-purpose output slot for the MMIO bus: a W-bit output register with atomic set, clear and toggle write ports, full register readback, and an optional timed pulse engine. The pulse engine inverts selected bits for a fixed number of cycles, then restores them automatically. It plugs into a standard MMIO slot, replacing the basic GPO where firmware needs read-modify-write-free bit control or self-timed strobes.

---
 rtl/chu_gpo_ext.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/chu_gpo_ext.sv
// ---------------------------------------------------------------------------
// chu_gpo_ext -- extended general-purpose output slot for the MMIO bus.
//
// A W-bit output register with atomic set / clear / toggle writes and full
// readback. With the macro GPO_PULSE_EN defined, a timed pulse engine is
// added: a PULSE write inverts the selected output bits for PULSE_CYC clock
// cycles, after which they are restored automatically. With GPO_PULSE_EN
// undefined, the pulse engine is absent and addresses 4 and 5 are unmapped.
//
// Register map (addr):
//   0 DATA   R/W  out_buf <= wr_data
//   1 SET    W    out_buf <= out_buf | wr_data
//   2 CLR    W    out_buf <= out_buf & ~wr_data
//   3 TOG    W    out_buf <= out_buf ^ wr_data
//   4 PULSE  R/W  nonzero: start/restart the pulse on these bits; zero: cancel
//   5 STATUS R    {busy, cnt[30:0]}
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   cs       in   slot chip select
//   read     in   read strobe (no side effects)
//   write    in   write strobe
//   addr     in   5-bit register offset
//   wr_data  in   32-bit write data, bits [W-1:0] used
//   rd_data  out  32-bit combinational read data, zero-extended
//   dout     out  W-bit registered output port
// ---------------------------------------------------------------------------
module chu_gpo_ext #(
  parameter int W         = 8,
  parameter int PULSE_CYC = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic [W-1:0] dout
);

  logic         wr;
  logic [W-1:0] wdat;
  logic [W-1:0] out_buf;
  logic [W-1:0] buf_next;
  logic [W-1:0] dout_next;

  // Read data is decoded from addr alone, and only the low W bits of the
  // write bus matter; the rest is intentionally left dangling.
  logic unused_bits;
  assign unused_bits = ^{read, wr_data};

  assign wr   = cs & write;
  assign wdat = wr_data[W-1:0];

  always_comb begin
    buf_next = out_buf;
    if (wr) begin
      case (addr)
        5'd0:    buf_next = wdat;
        5'd1:    buf_next = out_buf | wdat;
        5'd2:    buf_next = out_buf & ~wdat;
        5'd3:    buf_next = out_buf ^ wdat;
        default: buf_next = out_buf;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_buf <= '0;
    else       out_buf <= buf_next;
  end

`ifdef GPO_PULSE_EN

  localparam int CW = (PULSE_CYC < 1) ? 1 : $clog2(PULSE_CYC + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYC);

  logic [W-1:0]  mask;
  logic [W-1:0]  mask_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          busy;
  logic          busy_next;

  // Counter decrement that holds at zero instead of wrapping.
  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  always_comb begin
    cnt_next  = sat_dec(cnt);
    mask_next = mask;
    // Mask is dropped on the same edge the count reaches zero.
    if (cnt == CW'(1)) mask_next = '0;
    // A PULSE write overrides both expiry and any pulse in progress.
    if (wr && addr == 5'd4) begin
      if (wdat != '0) begin
        mask_next = wdat;
        cnt_next  = CNT_LOAD;
      end else begin
        mask_next = '0;
        cnt_next  = '0;
      end
    end
  end

  assign busy      = (cnt != '0);
  assign busy_next = (cnt_next != '0);
  assign dout_next = buf_next ^ (busy_next ? mask_next : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
      cnt  <= '0;
    end else begin
      mask <= mask_next;
      cnt  <= cnt_next;
    end
  end

  always_comb begin
    case (addr)
      5'd0:    rd_data = 32'(out_buf);
      5'd4:    rd_data = 32'(mask);
      5'd5:    rd_data = {busy, 31'(cnt)};
      default: rd_data = '0;
    endcase
  end

`else

  assign dout_next = buf_next;

  always_comb begin
    case (addr)
      5'd0:    rd_data = 32'(out_buf);
      default: rd_data = '0;
    endcase
  end

`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dout <= '0;
    else       dout <= dout_next;
  end

endmodule
